// File: rtl/sr_cmd_pkg.sv
// Shared constants for the SR flip-flop command generator: FSM state encoding
// and statistics counter width.
package sr_cmd_pkg;

  localparam int STAT_W = 8;

  // Enumerated FSM states, kept as plain 2-bit constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t PULSE_S = 2'd1;
  localparam state_t PULSE_R = 2'd2;
  localparam state_t GAP     = 2'd3;

endpackage

// File: rtl/sr_debounce.sv
// One button channel: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted rising level.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // rise is registered together with the flip so downstream sees it at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced, mutually exclusive S/R pulse generator for SR_ff.
// Optional SR_CMD_STATS_EN adds saturating set_cnt/rst_cnt pulse counters.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 2,
  parameter int GAP_CYCLES      = 1,
  parameter int SET_PRIORITY    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_rst,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
`ifdef SR_CMD_STATS_EN
  ,
  output logic [STAT_W-1:0] set_cnt,
  output logic [STAT_W-1:0] rst_cnt
`endif
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (PW > GW) ? PW : GW;
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic SET_WINS = (SET_PRIORITY != 0);

  logic          rise_s;
  logic          rise_r;
  logic          req_s;
  logic          req_r;
  logic          want_s;
  logic          want_r;
  logic          take_s;
  logic          take_r;
  logic          pend_s;
  logic          pend_r;
  state_t        state;
  state_t        state_n;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_n;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_set),
    .rise  (rise_s)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_rst),
    .rise  (rise_r)
  );

  // Simultaneous acceptances keep only the priority winner; the loser is dropped.
  assign req_s  = rise_s & (~rise_r | SET_WINS);
  assign req_r  = rise_r & (~rise_s | ~SET_WINS);
  assign want_s = pend_s | req_s;
  assign want_r = pend_r | req_r;

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    take_s  = 1'b0;
    take_r  = 1'b0;
    case (state)
      IDLE: begin
        if (want_s && (SET_WINS || !want_r)) begin
          state_n = PULSE_S;
          take_s  = 1'b1;
          tmr_n   = '0;
        end else if (want_r) begin
          state_n = PULSE_R;
          take_r  = 1'b1;
          tmr_n   = '0;
        end
      end
      PULSE_S, PULSE_R: begin
        if (tmr == PULSE_LAST) begin
          state_n = GAP;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      GAP: begin
        if (tmr == GAP_LAST) begin
          state_n = IDLE;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tmr_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so S/R/busy come straight off flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tmr      <= '0;
      pend_s   <= 1'b0;
      pend_r   <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_n;
      tmr      <= tmr_n;
      pend_s   <= want_s & ~take_s;
      pend_r   <= want_r & ~take_r;
      S        <= (state_n == PULSE_S);
      R        <= (state_n == PULSE_R);
      busy     <= (state_n != IDLE);
      conflict <= rise_s & rise_r;
    end
  end

`ifdef SR_CMD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_cnt <= '0;
      rst_cnt <= '0;
    end else begin
      if (take_s && (set_cnt != {STAT_W{1'b1}})) set_cnt <= set_cnt + STAT_W'(1);
      if (take_r && (rst_cnt != {STAT_W{1'b1}})) rst_cnt <= rst_cnt + STAT_W'(1);
    end
  end
`endif

endmodule
